mem_wb_skid: RTL and testbench

MEM_WB_SKID -- requirements
Module: mem_wb_skid

---
 rtl/wb_pkg.sv | 20 ++
 rtl/mem_wb_skid.sv | 102 ++++++++++
 tb/tb_mem_wb_skid.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB writeback skid buffer.
// wb_entry_t is sized from the package defaults.
package wb_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic              memtoreg;
    logic              regwrite;
    logic [REG_W-1:0]  rd;
  } wb_entry_t;

  // Register-file write enable: valid entry, writes enabled, not the zero register.
  function automatic logic wb_qual_we(input wb_entry_t e, input logic v);
    return v & e.regwrite & (e.rd != XZR_IDX);
  endfunction
endpackage

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with a one-entry skid.
// in_ready is derived only from state, so out_ready never reaches it combinationally.
module mem_wb_skid
  import wb_pkg::*;
#(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_W  = wb_pkg::REG_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_alu,
  input  logic [DATA_W-1:0]   in_mem,
  input  logic                in_memtoreg,
  input  logic                in_regwrite,
  input  logic [REG_W-1:0]    in_rd,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] wb_bus,
  output logic                wb_sel,
  output logic                wb_regwrite,
  output logic [REG_W-1:0]    wb_rd
);

  wb_entry_t r_head, r_skid;
  wb_entry_t w_head_nx, w_skid_nx, w_in_entry;
  logic      r_head_v, r_skid_v, r_wb_regwrite;
  logic      w_head_v_nx, w_skid_v_nx, w_push, w_pop;

  assign w_push = in_valid & ~r_skid_v;
  assign w_pop  = r_head_v & out_ready;

  // Pack the incoming fields into an entry.
  always_comb begin
    w_in_entry          = '0;
    w_in_entry.alu      = in_alu;
    w_in_entry.mem      = in_mem;
    w_in_entry.memtoreg = in_memtoreg;
    w_in_entry.regwrite = in_regwrite;
    w_in_entry.rd       = in_rd;
  end

  // Next-state for head and skid; a free head refills from skid before the input.
  always_comb begin
    w_head_nx   = r_head;
    w_skid_nx   = r_skid;
    w_head_v_nx = r_head_v;
    w_skid_v_nx = r_skid_v;
    if (flush) begin
      w_head_v_nx = 1'b0;
      w_skid_v_nx = 1'b0;
    end else if (w_pop || !r_head_v) begin
      if (r_skid_v) begin
        w_head_nx   = r_skid;
        w_head_v_nx = 1'b1;
        w_skid_v_nx = w_push;
        if (w_push) begin
          w_skid_nx = w_in_entry;
        end else begin
          w_skid_nx = r_skid;
        end
      end else if (w_push) begin
        w_head_nx   = w_in_entry;
        w_head_v_nx = 1'b1;
      end else begin
        w_head_v_nx = 1'b0;
      end
    end else if (w_push) begin
      w_skid_nx   = w_in_entry;
      w_skid_v_nx = 1'b1;
    end else begin
      w_skid_v_nx = r_skid_v;
    end
  end

  // Storage registers; the write enable is precomputed so it leaves a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head        <= '0;
      r_skid        <= '0;
      r_head_v      <= 1'b0;
      r_skid_v      <= 1'b0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_head        <= w_head_nx;
      r_skid        <= w_skid_nx;
      r_head_v      <= w_head_v_nx;
      r_skid_v      <= w_skid_v_nx;
      r_wb_regwrite <= wb_qual_we(w_head_nx, w_head_v_nx);
    end
  end

  assign in_ready    = ~r_skid_v;
  assign out_valid   = r_head_v;
  assign wb_bus      = {r_head.mem, r_head.alu};
  assign wb_sel      = r_head.memtoreg;
  assign wb_rd       = r_head.rd;
  assign wb_regwrite = r_wb_regwrite;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed and scoreboarded checks for mem_wb_skid.
module tb_mem_wb_skid;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready;
  logic [63:0]  in_alu, in_mem;
  logic         in_memtoreg, in_regwrite;
  logic [4:0]   in_rd;
  logic         flush, out_valid, out_ready;
  logic [127:0] wb_bus;
  logic         wb_sel, wb_regwrite;
  logic [4:0]   wb_rd;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [127:0] bus;
    logic         sel;
    logic         we;
    logic [4:0]   rd;
  } exp_t;
  exp_t sb[$];

  mem_wb_skid dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_mem(in_mem), .in_memtoreg(in_memtoreg),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .wb_bus(wb_bus),
    .wb_sel(wb_sel), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] mem, input logic sel, input logic we);
    in_valid    = v;
    in_rd       = rd;
    in_alu      = alu;
    in_mem      = mem;
    in_memtoreg = sel;
    in_regwrite = we;
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rnd_bus", wb_bus, e.bus);
      chk("rnd_sel", 128'(wb_sel), 128'(e.sel));
      chk("rnd_rd", 128'(wb_rd), 128'(e.rd));
      chk("rnd_we", 128'(wb_regwrite), 128'(e.we));
    end
  endtask

  initial begin
    exp_t e;
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_we", 128'(wb_regwrite), 128'd0);
    chk("rst_sel", 128'(wb_sel), 128'd0);
    chk("rst_rd", 128'(wb_rd), 128'd0);
    chk("rst_bus", wb_bus, 128'd0);
    reset_n = 1'b1;
    tick();

    // Single push, latency 1.
    out_ready = 1'b1;
    drive(1'b1, 5'd5, 64'h0FFF, 64'h0CCC, 1'b1, 1'b1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("single_valid", 128'(out_valid), 128'd1);
    chk("single_bus", wb_bus, {64'h0CCC, 64'h0FFF});
    chk("single_sel", 128'(wb_sel), 128'd1);
    chk("single_we", 128'(wb_regwrite), 128'd1);
    chk("single_rd", 128'(wb_rd), 128'd5);
    tick();
    chk("single_popped", 128'(out_valid), 128'd0);
    chk("single_we_idle", 128'(wb_regwrite), 128'd0);
    chk("single_bus_hold", wb_bus, {64'h0CCC, 64'h0FFF});

    // Back-pressure fills skid, then drains in order.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 64'hA1, 64'hA2, 1'b0, 1'b1);
    tick();
    chk("bp_a_valid", 128'(out_valid), 128'd1);
    chk("bp_a_rd", 128'(wb_rd), 128'd1);
    chk("bp_rdy_a", 128'(in_ready), 128'd1);
    drive(1'b1, 5'd2, 64'hB1, 64'hB2, 1'b1, 1'b1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("bp_rdy_b", 128'(in_ready), 128'd0);
    chk("bp_head_a", 128'(wb_rd), 128'd1);
    chk("bp_bus_a", wb_bus, {64'hA2, 64'hA1});
    tick();
    chk("bp_hold_rd", 128'(wb_rd), 128'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_valid", 128'(out_valid), 128'd1);
    chk("bp_b_rd", 128'(wb_rd), 128'd2);
    chk("bp_b_bus", wb_bus, {64'hB2, 64'hB1});
    chk("bp_b_sel", 128'(wb_sel), 128'd1);
    chk("bp_rdy_back", 128'(in_ready), 128'd1);
    tick();
    chk("bp_empty", 128'(out_valid), 128'd0);

    // Zero-register write suppressed; push+pop replaces head.
    drive(1'b1, 5'd31, 64'h31, 64'h13, 1'b0, 1'b1);
    tick();
    chk("xzr_valid", 128'(out_valid), 128'd1);
    chk("xzr_we", 128'(wb_regwrite), 128'd0);
    drive(1'b1, 5'd7, 64'h77, 64'h70, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("repl_valid", 128'(out_valid), 128'd1);
    chk("repl_rd", 128'(wb_rd), 128'd7);
    chk("repl_we_off", 128'(wb_regwrite), 128'd0);
    chk("repl_rdy", 128'(in_ready), 128'd1);
    tick();
    chk("repl_empty", 128'(out_valid), 128'd0);

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 64'hC1, 64'hC2, 1'b0, 1'b1);
    tick();
    drive(1'b1, 5'd11, 64'hD1, 64'hD2, 1'b0, 1'b1);
    tick();
    chk("fl_full", 128'(in_ready), 128'd0);
    flush = 1'b1;
    drive(1'b1, 5'd12, 64'hE1, 64'hE2, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("fl_valid", 128'(out_valid), 128'd0);
    chk("fl_rdy", 128'(in_ready), 128'd1);
    chk("fl_we", 128'(wb_regwrite), 128'd0);
    // Flush must also beat an accepted push.
    drive(1'b1, 5'd13, 64'hF1, 64'hF2, 1'b0, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 5'd14, 64'h41, 64'h42, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("fl_push_lost", 128'(out_valid), 128'd0);
    tick();
    chk("fl_push_gone", 128'(out_valid), 128'd0);

    // Asynchronous reset between edges.
    drive(1'b1, 5'd20, 64'h2020, 64'h0202, 1'b1, 1'b1);
    tick();
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    chk("ar_pre_valid", 128'(out_valid), 128'd1);
    chk("ar_pre_we", 128'(wb_regwrite), 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", 128'(out_valid), 128'd0);
    chk("ar_we", 128'(wb_regwrite), 128'd0);
    chk("ar_rdy", 128'(in_ready), 128'd1);
    chk("ar_bus", wb_bus, 128'd0);
    reset_n = 1'b1;
    tick();
    chk("ar_after", 128'(out_valid), 128'd0);

    // Random traffic against a scoreboard.
    for (int c = 0; c < 1000; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            {$urandom(), $urandom()}, {$urandom(), $urandom()},
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) pop_check();
      if (in_valid && in_ready) begin
        e.bus = {in_mem, in_alu};
        e.sel = in_memtoreg;
        e.rd  = in_rd;
        e.we  = in_regwrite && (in_rd != 5'd31);
        sb.push_back(e);
      end
      tick();
    end
    drive(1'b0, 5'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (out_valid) pop_check();
      tick();
    end
    chk("drain_sb_empty", 128'(sb.size()), 128'd0);
    chk("drain_out_valid", 128'(out_valid), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
